// File: rtl/dcm_reset_seq_if.sv
// Bus-side signal bundle for the DCM reset/lock sequencer: software request
// and raw LOCKED inputs in, DCM reset drive and status out.
interface dcm_reset_seq_if #(
    parameter int NUM_DCM = 2
);
    // No valid/ready pair: sw_reset_req is a level whose rising edge restarts the
    // sequence, dcm_locked is raw and asynchronous, and every status output is a
    // registered level that may be sampled at any time.
    logic               sw_reset_req;
    logic [NUM_DCM-1:0] dcm_locked;
    logic [NUM_DCM-1:0] dcm_rst;
    logic               clk_ok;
    logic               lock_fail;
    logic [1:0]         seq_state;
    logic [3:0]         retry_count;
    logic [7:0]         lost_lock_cnt;

    modport master (
        input  sw_reset_req, dcm_locked,
        output dcm_rst, clk_ok, lock_fail, seq_state, retry_count, lost_lock_cnt
    );

    modport slave (
        output sw_reset_req, dcm_locked,
        input  dcm_rst, clk_ok, lock_fail, seq_state, retry_count, lost_lock_cnt
    );
endinterface

// File: rtl/dcm_reset_seq.sv
// Reset/lock sequencer for Spartan-6 DCM_SP instances: holds them in reset,
// releases together or in cascade, retries on timeout, restarts on lock loss.
module dcm_reset_seq #(
    parameter int NUM_DCM      = 2,
    parameter int RST_CYCLES   = 30,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3,
    parameter int CASCADE      = 1,
    parameter int CNT_W        = 16
) (
    input  logic            xclk,
    input  logic            cpld_reset,
    dcm_reset_seq_if.master bus
);
    localparam int STG_W = (NUM_DCM > 1) ? $clog2(NUM_DCM) : 1;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [STG_W-1:0]   stage, stage_nx;
    logic [3:0]         retry, retry_nx;
    logic [7:0]         lost, lost_nx;
    logic [NUM_DCM-1:0] lock_m, lock_s;
    logic               h1, h2, sw_pulse;
    logic [NUM_DCM-1:0] rst_q, rst_nx;
    logic               ok_q, fail_q;
    logic               all_locked, stage_locked, last_stage, timeout;

    // LOCKED is asynchronous to xclk; the request level is edge-detected after two flops.
    always_ff @(posedge xclk or negedge cpld_reset) begin
        if (!cpld_reset) begin
            lock_m <= '0;
            lock_s <= '0;
            h1     <= 1'b0;
            h2     <= 1'b0;
        end else begin
            lock_m <= bus.dcm_locked;
            lock_s <= lock_m;
            h1     <= bus.sw_reset_req;
            h2     <= h1;
        end
    end

    assign sw_pulse     = h1 & ~h2;
    assign all_locked   = &lock_s;
    assign stage_locked = lock_s[stage];
    assign last_stage   = (stage == STG_W'(NUM_DCM - 1));
    assign timeout      = (cnt == CNT_W'(LOCK_TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stage_nx = stage;
        retry_nx = retry;
        lost_nx  = lost;
        if (sw_pulse) begin
            state_nx = HOLD;
            cnt_nx   = '0;
            stage_nx = '0;
            retry_nx = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state_nx = WAIT;
                        cnt_nx   = '0;
                        stage_nx = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // A lock arriving together with the timeout counts as an advance.
                    if (CASCADE == 0 && all_locked) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end else if (CASCADE != 0 && stage_locked) begin
                        cnt_nx = '0;
                        if (last_stage) state_nx = RUN;
                        else            stage_nx = stage + 1'b1;
                    end else if (timeout) begin
                        cnt_nx = '0;
                        if (retry < 4'(MAX_RETRY)) begin
                            retry_nx = retry + 1'b1;
                            state_nx = HOLD;
                        end else begin
                            state_nx = FAIL;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!all_locked) begin
                        state_nx = HOLD;
                        cnt_nx   = '0;
                        stage_nx = '0;
                        retry_nx = '0;
                        if (lost != 8'hFF) lost_nx = lost + 1'b1;
                    end
                end
                default: state_nx = FAIL;
            endcase
        end
    end

    // Outputs are decoded from the next state so they update on the same edge as the FSM.
    always_comb begin
        rst_nx = '1;
        case (state_nx)
            WAIT: begin
                if (CASCADE == 0) begin
                    rst_nx = '0;
                end else begin
                    for (int i = 0; i < NUM_DCM; i++) rst_nx[i] = (i > int'(stage_nx));
                end
            end
            RUN:     rst_nx = '0;
            default: rst_nx = '1;
        endcase
    end

    always_ff @(posedge xclk or negedge cpld_reset) begin
        if (!cpld_reset) begin
            state  <= HOLD;
            cnt    <= '0;
            stage  <= '0;
            retry  <= '0;
            lost   <= '0;
            rst_q  <= '1;
            ok_q   <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            stage  <= stage_nx;
            retry  <= retry_nx;
            lost   <= lost_nx;
            rst_q  <= rst_nx;
            ok_q   <= (state_nx == RUN);
            fail_q <= (state_nx == FAIL);
        end
    end

    assign bus.dcm_rst       = rst_q;
    assign bus.clk_ok        = ok_q;
    assign bus.lock_fail     = fail_q;
    assign bus.seq_state     = state;
    assign bus.retry_count   = retry;
    assign bus.lost_lock_cnt = lost;
endmodule

// File: tb/tb_dcm_reset_seq.sv
// Bench for dcm_reset_seq: cascade instance covers the full sequence, a second
// non-cascade instance covers simultaneous release after an async reset.
module tb_dcm_reset_seq;
    localparam int W = 18;

    logic xclk = 1'b0;
    logic cpld_reset = 1'b0;
    always #5 xclk = ~xclk;

    dcm_reset_seq_if #(.NUM_DCM(2)) bus_c ();
    dcm_reset_seq_if #(.NUM_DCM(2)) bus_p ();

    dcm_reset_seq #(.NUM_DCM(2), .RST_CYCLES(30), .LOCK_TIMEOUT(64), .MAX_RETRY(2),
                    .CASCADE(1), .CNT_W(16))
        dut_c (.xclk(xclk), .cpld_reset(cpld_reset), .bus(bus_c));

    dcm_reset_seq #(.NUM_DCM(2), .RST_CYCLES(30), .LOCK_TIMEOUT(64), .MAX_RETRY(2),
                    .CASCADE(0), .CNT_W(16))
        dut_p (.xclk(xclk), .cpld_reset(cpld_reset), .bus(bus_p));

    // {dcm_rst, clk_ok, lock_fail, seq_state, retry_count, lost_lock_cnt}
    logic [W-1:0] obs_c, obs_p, exp;
    assign obs_c = {bus_c.dcm_rst, bus_c.clk_ok, bus_c.lock_fail, bus_c.seq_state,
                    bus_c.retry_count, bus_c.lost_lock_cnt};
    assign obs_p = {bus_p.dcm_rst, bus_p.clk_ok, bus_p.lock_fail, bus_p.seq_state,
                    bus_p.retry_count, bus_p.lost_lock_cnt};

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [W-1:0] pack(logic [1:0] rst, logic ok, logic fl,
                                          logic [1:0] st, logic [3:0] rc, logic [7:0] lost);
        return {rst, ok, fl, st, rc, lost};
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge xclk);
            #1;
        end
    endtask

    task automatic test_reset();
        tick(2);
        exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd0));
        exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd0));
        exp = exp_q.pop_front(); n_checks++;
        if (obs_c !== exp) begin n_fail++; $display("FAIL reset_cascade: got %h expected %h", obs_c, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (obs_p !== exp) begin n_fail++; $display("FAIL reset_parallel: got %h expected %h", obs_p, exp); end
    endtask

    task automatic test_power_up();
        cpld_reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            exp_q.push_back(k < 30 ? pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd0)
                                   : pack(2'b10, 0, 0, 2'd1, 4'd0, 8'd0));
            tick(1);
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL power_up edge %0d: got %h expected %h", k, obs_c, exp); end
        end
    endtask

    task automatic test_cascade_lock();
        tick(10);
        exp_q.push_back(pack(2'b10, 0, 0, 2'd1, 4'd0, 8'd0));
        exp = exp_q.pop_front(); n_checks++;
        if (obs_c !== exp) begin n_fail++; $display("FAIL cascade_wait10: got %h expected %h", obs_c, exp); end
        bus_c.dcm_locked = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(pack(k < 3 ? 2'b10 : 2'b00, 0, 0, 2'd1, 4'd0, 8'd0));
            tick(1);
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL cascade_lock0 edge %0d: got %h expected %h", k, obs_c, exp); end
        end
        bus_c.dcm_locked = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(k < 3 ? pack(2'b00, 0, 0, 2'd1, 4'd0, 8'd0)
                                  : pack(2'b00, 1, 0, 2'd2, 4'd0, 8'd0));
            tick(1);
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL cascade_lock1 edge %0d: got %h expected %h", k, obs_c, exp); end
        end
    endtask

    task automatic test_lock_loss();
        bus_c.dcm_locked = 2'b01;
        tick(1);
        bus_c.dcm_locked = 2'b11;
        exp_q.push_back(pack(2'b00, 1, 0, 2'd2, 4'd0, 8'd0));
        exp = exp_q.pop_front(); n_checks++;
        if (obs_c !== exp) begin n_fail++; $display("FAIL loss_edge1: got %h expected %h", obs_c, exp); end
        tick(1);
        exp_q.push_back(pack(2'b00, 1, 0, 2'd2, 4'd0, 8'd0));
        exp = exp_q.pop_front(); n_checks++;
        if (obs_c !== exp) begin n_fail++; $display("FAIL loss_edge2: got %h expected %h", obs_c, exp); end
        tick(1);
        exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd1));
        exp = exp_q.pop_front(); n_checks++;
        if (obs_c !== exp) begin n_fail++; $display("FAIL loss_detect: got %h expected %h", obs_c, exp); end
        for (int k = 1; k <= 32; k++) begin
            if (k < 30)       exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd1));
            else if (k == 30) exp_q.push_back(pack(2'b10, 0, 0, 2'd1, 4'd0, 8'd1));
            else if (k == 31) exp_q.push_back(pack(2'b00, 0, 0, 2'd1, 4'd0, 8'd1));
            else              exp_q.push_back(pack(2'b00, 1, 0, 2'd2, 4'd0, 8'd1));
            tick(1);
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL loss_relock edge %0d: got %h expected %h", k, obs_c, exp); end
        end
    endtask

    task automatic test_lost_saturation();
        for (int n = 2; n <= 300; n++) begin
            bus_c.dcm_locked = 2'b01;
            tick(1);
            bus_c.dcm_locked = 2'b11;
            tick(2);
            exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'd0, (n > 255) ? 8'd255 : 8'(n)));
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL saturate loss %0d: got %h expected %h", n, obs_c, exp); end
            tick(32);
            exp_q.push_back(pack(2'b00, 1, 0, 2'd2, 4'd0, (n > 255) ? 8'd255 : 8'(n)));
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL saturate relock %0d: got %h expected %h", n, obs_c, exp); end
        end
    endtask

    task automatic test_timeout_retry();
        bus_c.dcm_locked = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(k < 3 ? pack(2'b00, 1, 0, 2'd2, 4'd0, 8'd255)
                                  : pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd255));
            tick(1);
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL drop_all edge %0d: got %h expected %h", k, obs_c, exp); end
        end
        for (int a = 0; a < 3; a++) begin
            for (int k = 1; k <= 94; k++) begin
                if (k < 30)       exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'(a), 8'd255));
                else if (k < 94)  exp_q.push_back(pack(2'b10, 0, 0, 2'd1, 4'(a), 8'd255));
                else if (a < 2)   exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'(a + 1), 8'd255));
                else              exp_q.push_back(pack(2'b11, 0, 1, 2'd3, 4'd2, 8'd255));
                tick(1);
                exp = exp_q.pop_front(); n_checks++;
                if (obs_c !== exp) begin n_fail++; $display("FAIL retry %0d edge %0d: got %h expected %h", a, k, obs_c, exp); end
            end
        end
        for (int k = 1; k <= 5; k++) begin
            tick(20);
            exp_q.push_back(pack(2'b11, 0, 1, 2'd3, 4'd2, 8'd255));
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL fail_hold %0d: got %h expected %h", k, obs_c, exp); end
        end
    endtask

    task automatic test_recovery();
        bus_c.sw_reset_req = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == 1)      exp_q.push_back(pack(2'b11, 0, 1, 2'd3, 4'd2, 8'd255));
            else if (k < 32) exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd255));
            else             exp_q.push_back(pack(2'b10, 0, 0, 2'd1, 4'd0, 8'd255));
            tick(1);
            exp = exp_q.pop_front(); n_checks++;
            if (obs_c !== exp) begin n_fail++; $display("FAIL recovery edge %0d: got %h expected %h", k, obs_c, exp); end
            if (k == 5) bus_c.sw_reset_req = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        tick(40);
        exp_q.push_back(pack(2'b10, 0, 0, 2'd1, 4'd0, 8'd255));
        exp = exp_q.pop_front(); n_checks++;
        if (obs_c !== exp) begin n_fail++; $display("FAIL wait_cnt40: got %h expected %h", obs_c, exp); end
        #3;
        cpld_reset = 1'b0;
        #1;
        exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd0));
        exp_q.push_back(pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd0));
        exp = exp_q.pop_front(); n_checks++;
        if (obs_c !== exp) begin n_fail++; $display("FAIL async_reset_cascade: got %h expected %h", obs_c, exp); end
        exp = exp_q.pop_front(); n_checks++;
        if (obs_p !== exp) begin n_fail++; $display("FAIL async_reset_parallel: got %h expected %h", obs_p, exp); end
    endtask

    task automatic test_parallel_release();
        tick(1);
        bus_p.dcm_locked = 2'b00;
        cpld_reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            exp_q.push_back(k < 30 ? pack(2'b11, 0, 0, 2'd0, 4'd0, 8'd0)
                                   : pack(2'b00, 0, 0, 2'd1, 4'd0, 8'd0));
            tick(1);
            exp = exp_q.pop_front(); n_checks++;
            if (obs_p !== exp) begin n_fail++; $display("FAIL parallel_hold edge %0d: got %h expected %h", k, obs_p, exp); end
        end
        exp_q.push_back(pack(2'b10, 0, 0, 2'd1, 4'd0, 8'd0));
        exp = exp_q.pop_front(); n_checks++;
        if (obs_c !== exp) begin n_fail++; $display("FAIL cascade_after_reset: got %h expected %h", obs_c, exp); end
        bus_p.dcm_locked = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(k < 3 ? pack(2'b00, 0, 0, 2'd1, 4'd0, 8'd0)
                                  : pack(2'b00, 1, 0, 2'd2, 4'd0, 8'd0));
            tick(1);
            exp = exp_q.pop_front(); n_checks++;
            if (obs_p !== exp) begin n_fail++; $display("FAIL parallel_lock edge %0d: got %h expected %h", k, obs_p, exp); end
        end
    endtask

    initial begin
        bus_c.sw_reset_req = 1'b0;
        bus_c.dcm_locked   = 2'b00;
        bus_p.sw_reset_req = 1'b0;
        bus_p.dcm_locked   = 2'b00;
        test_reset();
        test_power_up();
        test_cascade_lock();
        test_lock_loss();
        test_lost_saturation();
        test_timeout_retry();
        test_recovery();
        test_async_reset();
        test_parallel_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
